// File: rtl/register_pipe_hs_if.sv
// Handshake bundle for register_pipe_hs: upstream valid/ready/data, downstream
// valid/ready/data, flush and occupancy count.
interface register_pipe_hs_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  D;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Q;
    logic          flush;
    logic [CW-1:0] count;

    // master: the surrounding logic that feeds and drains the pipe
    modport master (
        output in_valid, D, out_ready, flush,
        input  in_ready, out_valid, Q, count
    );

    modport slave (
        input  in_valid, D, out_ready, flush,
        output in_ready, out_valid, Q, count
    );
endinterface

// File: rtl/register_pipe_hs.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, bubble
// collapsing, synchronous flush and a registered occupancy count.
module register_pipe_hs #(
    parameter int unsigned   W         = 16,
    parameter int unsigned   DEPTH     = 3,
    parameter logic [W-1:0]  RESET_VAL = '0,
    localparam int unsigned  CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    register_pipe_hs_if.slave p
);

    logic [W-1:0]     data  [DEPTH];
    logic [W-1:0]     src_d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] adv;
    logic             chain;
    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    cnt;

    // A stage advances when downstream accepts or any stage at/after it is empty;
    // folded as a running OR from the tail so no signal feeds back on itself.
    always_comb begin
        chain = p.out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = chain | ~v[i];
            adv[i] = chain;
        end
    end

    always_comb begin
        src_d[0] = p.D;
        src_v[0] = p.in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            src_d[i] = data[i-1];
            src_v[i] = v[i-1];
        end
    end

    assign in_ready  = adv[0] & ~p.flush;
    assign in_xfer   = p.in_valid & in_ready;
    assign out_xfer  = v[DEPTH-1] & p.out_ready;

    assign p.in_ready  = in_ready;
    assign p.out_valid = v[DEPTH-1];
    assign p.Q         = data[DEPTH-1];
    assign p.count     = cnt;

    // Data registers: flush leaves contents in place, only the valids drop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
        end else if (!p.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) data[i] <= src_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || p.flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) v[i] <= src_v[i];
            end
        end
    end

    // Occupancy tracks popcount(v): +1 per accept, -1 per delivery
    always_ff @(posedge clk) begin
        if (rst || p.flush) begin
            cnt <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_register_pipe_hs.sv
// Scoreboard bench for register_pipe_hs (W=16, DEPTH=3, RESET_VAL=0).
module tb_register_pipe_hs;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 3;

    logic clk = 1'b0;
    logic rst;

    register_pipe_hs_if #(.W(W), .DEPTH(DEPTH)) bus ();

    register_pipe_hs #(
        .W(W), .DEPTH(DEPTH), .RESET_VAL(16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .p   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [W-1:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc1_cyc = -1;
    int out1_cyc = -1;
    int last_waits = 0;
    bit chk_en = 1'b0;
    bit hold_prev = 1'b0;
    logic [W-1:0] hold_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on each delivery, checks Q stability under stall
    always @(negedge clk) begin
        if (hold_prev) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_q", 32'(bus.Q), 32'(hold_q));
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(bus.Q), 32'hFFFF_FFFF);
            end else begin
                check("out_word", 32'(bus.Q), 32'(sb.pop_front()));
            end
            if (bus.Q == 16'd1) out1_cyc = cyc;
        end
        hold_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        hold_q    = bus.Q;
    end

    always begin
        @(posedge clk);
        #2;
        if (chk_en) check("count", 32'(bus.count), 32'(sb.size()));
    end

    task automatic send(input logic [W-1:0] d);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.D        = d;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(d);
                if (d == 16'd1) acc1_cyc = cyc + 1;
                break;
            end
            w++;
            if (w > 50) begin
                check("send_timeout", 32'(w), 32'd0);
                break;
            end
        end
        last_waits = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        idle(1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.D         = 16'hABCD;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.Q), 32'h0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_en = 1'b1;

        // Streaming with out_ready high
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        check("steady_count", 32'(bus.count), 32'd3);
        send(16'd5);
        drain();
        check("latency", 32'(out1_cyc - acc1_cyc), 32'(DEPTH - 1));

        // Backpressure fill
        bus.out_ready = 1'b0;
        send(16'd10);
        send(16'd11);
        send(16'd12);
        bus.in_valid = 1'b1;
        bus.D        = 16'd13;
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_count", 32'(bus.count), 32'd3);
        check("full_q", 32'(bus.Q), 32'd10);
        idle(2);
        bus.out_ready = 1'b1;
        send(16'd13);
        check("accept_on_release", 32'(last_waits), 32'd0);
        drain();

        // Bubbles with toggling backpressure
        bus.out_ready = 1'b0;
        fork
            begin
                repeat (14) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ~bus.out_ready;
                end
            end
            begin
                send(16'd7);
                idle(2);
                send(16'd8);
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Flush while full, with a word offered the same cycle
        bus.out_ready = 1'b0;
        send(16'd20);
        send(16'd21);
        send(16'd22);
        bus.in_valid = 1'b1;
        bus.D        = 16'd23;
        bus.flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        hold_prev = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_count", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b1;
        send(16'd24);
        drain();

        // Reset together with flush while full
        bus.out_ready = 1'b0;
        send(16'd30);
        send(16'd31);
        send(16'd32);
        rst       = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.flush = 1'b0;
        sb.delete();
        hold_prev = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_q", 32'(bus.Q), 32'h0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b1;
        idle(5);
        send(16'd40);
        drain();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
